// File: rtl/mips_cpu_mem_arbiter_pkg.sv
// mips_cpu_mem_pkg
// Shared types and constants for the CPU memory-port arbiter.
//   state_t : arbiter FSM states
//   grant_t : which CPU port currently owns (or last owned) the memory port
//   BE_WORD : full-word byteenable used for instruction fetches
package mips_cpu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RDWAIT,
      RESP
   } state_t;

   typedef enum logic {
      GRANT_INST,
      GRANT_DATA
   } grant_t;

   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_cpu_mem_arbiter_if.sv
// mips_cpu_mem_arbiter_if
// Bundles the two CPU requester ports and the Avalon-style memory port.
//   i_*   : instruction-fetch requester (read only)
//   d_*   : data requester (read or write, byteenabled)
//   mem_* : single shared memory port
// Modports:
//   slave  : arbiter view (accepts CPU requests, drives the memory port)
//   master : environment view (CPU requesters plus memory)
interface mips_cpu_mem_arbiter_if;

   logic        i_req;
   logic [31:0] i_addr;
   logic        i_done;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_done;
   logic [31:0] d_rdata;

   logic [31:0] mem_address;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;

   modport slave (
      input  i_req, i_addr,
      output i_done, i_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_be,
      output d_done, d_rdata,
      output mem_address, mem_write, mem_read, mem_writedata, mem_byteenable,
      input  mem_readdata, mem_waitrequest
   );

   modport master (
      output i_req, i_addr,
      input  i_done, i_rdata,
      output d_req, d_we, d_addr, d_wdata, d_be,
      input  d_done, d_rdata,
      input  mem_address, mem_write, mem_read, mem_writedata, mem_byteenable,
      output mem_readdata, mem_waitrequest
   );

endinterface

// File: rtl/mips_cpu_mem_arbiter_rr_arb.sv
// mips_cpu_mem_rr_arb
// Combinational two-way round-robin picker.
//   req[0]     : instruction port requesting
//   req[1]     : data port requesting
//   last_grant : port that won the previous arbitration
//   valid      : at least one request is present
//   grant      : winning port (only meaningful when valid)
module mips_cpu_mem_rr_arb
   import mips_cpu_mem_pkg::*;
(
   input  logic [1:0] req,
   input  grant_t     last_grant,
   output logic       valid,
   output grant_t     grant
);

   // A lone requester always wins; on a tie the port that did not win last time goes next.
   always_comb begin
      valid = |req;
      grant = GRANT_INST;
      case (req)
         2'b01:   grant = GRANT_INST;
         2'b10:   grant = GRANT_DATA;
         2'b11:   grant = (last_grant == GRANT_DATA) ? GRANT_INST : GRANT_DATA;
         default: grant = GRANT_INST;
      endcase
   end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter
// Shares one Avalon-style memory port between the CPU fetch and data ports.
// One request is latched at a time, held stable on the memory port through
// waitrequest, and completed with a one-cycle done pulse to the winner.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : requester and memory signals (slave modport)
//   err   : sticky watchdog flag, set after TIMEOUT consecutive stalled BUS cycles
module mips_cpu_mem_arbiter
   import mips_cpu_mem_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_cpu_mem_arbiter_if.slave bus,
   output logic                  err
);

   localparam int               CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state_q;
   state_t           state_d;
   grant_t           last_grant_q;
   grant_t           arb_grant;
   logic             arb_valid;
   logic             stalled;

   logic             we_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       be_q;
   logic [31:0]      i_rdata_q;
   logic [31:0]      d_rdata_q;

   logic [CNT_W-1:0] wait_cnt_q;
   logic [CNT_W-1:0] wait_cnt_d;
   logic             err_q;

   mips_cpu_mem_rr_arb u_rr_arb (
      .req        ({bus.d_req, bus.i_req}),
      .last_grant (last_grant_q),
      .valid      (arb_valid),
      .grant      (arb_grant)
   );

   // waitrequest only matters while a transfer is being offered to memory.
   assign stalled = (state_q == BUS) && bus.mem_waitrequest;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: reads take an extra cycle to collect readdata, writes go straight to RESP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arb_valid) state_d = BUS;
         BUS:     if (!bus.mem_waitrequest) state_d = we_q ? RESP : RDWAIT;
         RDWAIT:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch: fields are captured once at grant so later requester changes are ignored.
   // last_grant doubles as the owner of the in-flight transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= GRANT_DATA;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
      end else if ((state_q == IDLE) && arb_valid) begin
         last_grant_q <= arb_grant;
         if (arb_grant == GRANT_INST) begin
            we_q    <= 1'b0;
            addr_q  <= bus.i_addr;
            wdata_q <= '0;
            be_q    <= BE_WORD;
         end else begin
            we_q    <= bus.d_we;
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
            be_q    <= bus.d_be;
         end
      end
   end

   // Read data capture: memory presents readdata during RDWAIT; each port keeps its last word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else if (state_q == RDWAIT) begin
         if (last_grant_q == GRANT_INST) begin
            i_rdata_q <= bus.mem_readdata;
         end else begin
            d_rdata_q <= bus.mem_readdata;
         end
      end
   end

   // Watchdog count: saturates at TIMEOUT and drops to zero whenever the FSM is not stalled in BUS.
   always_comb begin
      wait_cnt_d = '0;
      if (stalled) begin
         wait_cnt_d = (wait_cnt_q == TIMEOUT_C) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
   end

   // Watchdog register and sticky error; the stalled transfer itself is left running.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_q | (wait_cnt_d == TIMEOUT_C);
      end
   end

   // Memory strobes and done pulses are pure decodes of registered state.
   assign bus.mem_address    = addr_q;
   assign bus.mem_writedata  = wdata_q;
   assign bus.mem_byteenable = be_q;
   assign bus.mem_read       = (state_q == BUS) && !we_q;
   assign bus.mem_write      = (state_q == BUS) && we_q;

   assign bus.i_done  = (state_q == RESP) && (last_grant_q == GRANT_INST);
   assign bus.d_done  = (state_q == RESP) && (last_grant_q == GRANT_DATA);
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;

   assign err = err_q;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// tb_mips_cpu_mem_arbiter
// Directed bench for the CPU memory-port arbiter, built with TIMEOUT=4 so the
// watchdog can be reached quickly. A small word memory sits on the memory port.
module tb_mips_cpu_mem_arbiter;

   logic clk = 1'b0;
   logic reset;
   logic err;

   int pass_count;
   int check_count;

   logic rand_mode;
   logic wait_rand;
   logic wait_script;

   logic [31:0] mem   [16];
   logic [31:0] model [16];

   mips_cpu_mem_arbiter_if bus();

   mips_cpu_mem_arbiter #(.TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .err   (err)
   );

   always #5 clk = ~clk;

   assign bus.mem_waitrequest = rand_mode ? wait_rand : wait_script;

   // Reset contents of the mock memory, shared with the scoreboard model.
   function automatic logic [31:0] init_word(input int i);
      if (i == 0) return 32'h2402000A;
      if (i == 4) return 32'h11223344;
      return {8'hA5, 8'(i), 8'h5A, 8'(i)};
   endfunction

   // Mock memory: readdata appears the cycle after an accepted read; writes honour byteenable.
   always @(posedge clk) begin
      wait_rand <= ($urandom_range(0, 2) == 0);
      if (reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
         bus.mem_readdata <= '0;
      end else begin
         if (bus.mem_read && !bus.mem_waitrequest)
            bus.mem_readdata <= mem[bus.mem_address[5:2]];
         if (bus.mem_write && !bus.mem_waitrequest) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_byteenable[b])
                  mem[bus.mem_address[5:2]][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got no finish, want finish before 500000ns");
      $fatal(1, "[TB] aborting");
   end

   // Runs one request to completion and checks its done pulse and read data.
   task automatic run_txn(input bit is_inst, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp, input string tag);
      bit got;
      bit stray;
      logic [31:0] rdata;
      got   = 1'b0;
      stray = 1'b0;
      if (is_inst) begin
         bus.i_addr = addr;
         bus.i_req  = 1'b1;
      end else begin
         bus.d_we    = we;
         bus.d_addr  = addr;
         bus.d_wdata = wdata;
         bus.d_be    = be;
         bus.d_req   = 1'b1;
      end
      for (int c = 0; c < 64 && !got; c++) begin
         @(negedge clk);
         if (is_inst ? bus.d_done : bus.i_done) stray = 1'b1;
         if (is_inst ? bus.i_done : bus.d_done) got = 1'b1;
      end
      rdata = is_inst ? bus.i_rdata : bus.d_rdata;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      check_count++;
      if (!got) $display("[TB] FAIL %s_done: got no done in 64 cycles, want done", tag);
      else pass_count++;
      if (got && !we) begin
         check_count++;
         if (rdata !== exp) $display("[TB] FAIL %s_rdata: got %h want %h", tag, rdata, exp);
         else pass_count++;
      end
      check_count++;
      if (stray) $display("[TB] FAIL %s_other_done: got 1 want 0", tag);
      else pass_count++;
      @(negedge clk);
      check_count++;
      if ((bus.i_done | bus.d_done) !== 1'b0)
         $display("[TB] FAIL %s_single_done: got %b%b want 00", tag, bus.i_done, bus.d_done);
      else pass_count++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_count++;
      if ({bus.mem_read, bus.mem_write, bus.i_done, bus.d_done, err} !== 5'b0)
         $display("[TB] FAIL reset_ctrl: got %b want 00000",
                  {bus.mem_read, bus.mem_write, bus.i_done, bus.d_done, err});
      else pass_count++;
      check_count++;
      if ({bus.i_rdata, bus.d_rdata} !== 64'h0)
         $display("[TB] FAIL reset_rdata: got %h/%h want 0/0", bus.i_rdata, bus.d_rdata);
      else pass_count++;
      check_count++;
      if ({bus.mem_address, bus.mem_byteenable} !== 36'h0)
         $display("[TB] FAIL reset_mem_bus: got %h/%h want 0/0", bus.mem_address, bus.mem_byteenable);
      else pass_count++;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fetch();
      wait_script = 1'b0;
      bus.i_addr  = 32'hBFC00000;
      bus.i_req   = 1'b1;
      @(negedge clk);
      check_count++;
      if ({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_byteenable} !== {2'b10, 32'hBFC00000, 4'hF})
         $display("[TB] FAIL fetch_bus: got %b%b %h %h want 10 bfc00000 f",
                  bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_byteenable);
      else pass_count++;
      @(negedge clk);
      check_count++;
      if ({bus.i_done, bus.mem_read} !== 2'b00)
         $display("[TB] FAIL fetch_cycle2: got done=%b read=%b want 0 0", bus.i_done, bus.mem_read);
      else pass_count++;
      @(negedge clk);
      check_count++;
      if ({bus.i_done, bus.d_done} !== 2'b10)
         $display("[TB] FAIL fetch_done_cycle3: got %b%b want 10", bus.i_done, bus.d_done);
      else pass_count++;
      check_count++;
      if (bus.i_rdata !== 32'h2402000A)
         $display("[TB] FAIL fetch_rdata: got %h want 2402000a", bus.i_rdata);
      else pass_count++;
      bus.i_req = 1'b0;
      @(negedge clk);
      check_count++;
      if (bus.i_done !== 1'b0) $display("[TB] FAIL fetch_pulse_width: got 1 want 0");
      else pass_count++;
   endtask

   task automatic test_write_wait();
      wait_script = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h10;
      bus.d_wdata = 32'hDEADBEEF;
      bus.d_be    = 4'b0011;
      bus.d_req   = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 2) begin
            bus.d_wdata = 32'h0;
            bus.d_addr  = 32'h20;
         end
         check_count++;
         if ({bus.mem_write, bus.mem_read, bus.d_done, bus.mem_address, bus.mem_writedata, bus.mem_byteenable}
             !== {3'b100, 32'h10, 32'hDEADBEEF, 4'b0011})
            $display("[TB] FAIL write_hold_c%0d: got w%b r%b done%b %h %h %h want w1 r0 done0 10 deadbeef 3",
                     k, bus.mem_write, bus.mem_read, bus.d_done, bus.mem_address,
                     bus.mem_writedata, bus.mem_byteenable);
         else pass_count++;
         if (k == 4) begin
            check_count++;
            if (err !== 1'b0) $display("[TB] FAIL write_err_below_timeout: got 1 want 0");
            else pass_count++;
            wait_script = 1'b0;
         end
      end
      @(negedge clk);
      check_count++;
      if ({bus.d_done, bus.i_done} !== 2'b10)
         $display("[TB] FAIL write_done_cycle5: got d%b i%b want d1 i0", bus.d_done, bus.i_done);
      else pass_count++;
      check_count++;
      if (bus.d_rdata !== 32'h0) $display("[TB] FAIL write_keeps_rdata: got %h want 0", bus.d_rdata);
      else pass_count++;
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      @(negedge clk);
      check_count++;
      if (bus.d_done !== 1'b0) $display("[TB] FAIL write_pulse_width: got 1 want 0");
      else pass_count++;
   endtask

   task automatic test_readback();
      run_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h1122BEEF, "readback");
      check_count++;
      if (bus.d_rdata[15:0] !== 16'hBEEF)
         $display("[TB] FAIL readback_low_half: got %h want beef", bus.d_rdata[15:0]);
      else pass_count++;
      check_count++;
      if (bus.i_rdata !== 32'h2402000A)
         $display("[TB] FAIL readback_i_rdata_held: got %h want 2402000a", bus.i_rdata);
      else pass_count++;
   endtask

   task automatic test_tie();
      bit overlap;
      int n;
      logic [5:0] seq;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      overlap    = 1'b0;
      n          = 0;
      seq        = '0;
      bus.i_addr = 32'h0;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h14;
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      for (int c = 0; c < 60 && n < 6; c++) begin
         @(negedge clk);
         if (bus.i_done && bus.d_done) overlap = 1'b1;
         if (bus.i_done || bus.d_done) begin
            seq = {seq[4:0], bus.d_done};
            n++;
         end
         if (n == 6) begin
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
         end
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      check_count++;
      if (n != 6) $display("[TB] FAIL tie_count: got %0d dones want 6", n);
      else pass_count++;
      check_count++;
      if (seq !== 6'b010101) $display("[TB] FAIL tie_order: got %b want 010101 (0=inst)", seq);
      else pass_count++;
      check_count++;
      if (overlap) $display("[TB] FAIL tie_overlap: got overlapping dones want none");
      else pass_count++;
      check_count++;
      if ({bus.i_rdata, bus.d_rdata} !== {32'h2402000A, init_word(5)})
         $display("[TB] FAIL tie_rdata: got %h/%h want 2402000a/%h", bus.i_rdata, bus.d_rdata, init_word(5));
      else pass_count++;
      @(negedge clk);
   endtask

   task automatic test_watchdog();
      check_count++;
      if (err !== 1'b0) $display("[TB] FAIL wdog_start: got 1 want 0");
      else pass_count++;
      wait_script = 1'b1;
      bus.i_addr  = 32'h0;
      bus.i_req   = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 4) begin
            check_count++;
            if (err !== 1'b0) $display("[TB] FAIL wdog_early: got 1 want 0 after 3 stalls");
            else pass_count++;
         end
         if (k == 5) begin
            check_count++;
            if (err !== 1'b1) $display("[TB] FAIL wdog_rise: got 0 want 1 after 4 stalls");
            else pass_count++;
         end
         if (k == 7) begin
            check_count++;
            if (bus.mem_read !== 1'b1) $display("[TB] FAIL wdog_no_abort: got read=0 want 1");
            else pass_count++;
            wait_script = 1'b0;
         end
         if (k == 9) begin
            check_count++;
            if ({bus.i_done, bus.i_rdata} !== {1'b1, 32'h2402000A})
               $display("[TB] FAIL wdog_complete: got done=%b %h want done=1 2402000a", bus.i_done, bus.i_rdata);
            else pass_count++;
            bus.i_req = 1'b0;
         end
         if (k == 10) begin
            check_count++;
            if (err !== 1'b1) $display("[TB] FAIL wdog_sticky: got 0 want 1");
            else pass_count++;
         end
      end
   endtask

   task automatic test_async_reset();
      wait_script = 1'b1;
      bus.i_addr  = 32'h8;
      bus.i_req   = 1'b1;
      @(negedge clk);
      check_count++;
      if (bus.mem_read !== 1'b1) $display("[TB] FAIL areset_pre: got read=0 want 1");
      else pass_count++;
      #2;
      reset = 1'b1;
      #1;
      check_count++;
      if ({bus.mem_read, bus.mem_write, bus.i_done, bus.d_done, err} !== 5'b0)
         $display("[TB] FAIL areset_immediate: got %b want 00000",
                  {bus.mem_read, bus.mem_write, bus.i_done, bus.d_done, err});
      else pass_count++;
      bus.i_req = 1'b0;
      @(negedge clk);
      reset       = 1'b0;
      wait_script = 1'b0;
      @(negedge clk);
      run_txn(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, init_word(2), "areset_after");
   endtask

   task automatic test_random();
      int kind;
      logic [3:0]  idx;
      logic [31:0] wdata;
      logic [3:0]  be;
      for (int i = 0; i < 16; i++) model[i] = init_word(i);
      rand_mode = 1'b1;
      for (int t = 0; t < 200; t++) begin
         kind  = $urandom_range(0, 2);
         idx   = 4'($urandom_range(0, 15));
         wdata = $urandom;
         be    = 4'($urandom_range(1, 15));
         case (kind)
            0: run_txn(1'b1, 1'b0, {26'h0, idx, 2'b00}, 32'h0, 4'hF, model[idx], "rand_inst");
            1: run_txn(1'b0, 1'b0, {26'h0, idx, 2'b00}, 32'h0, 4'hF, model[idx], "rand_dread");
            default: begin
               run_txn(1'b0, 1'b1, {26'h0, idx, 2'b00}, wdata, be, 32'h0, "rand_dwrite");
               for (int b = 0; b < 4; b++)
                  if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
            end
         endcase
      end
      rand_mode = 1'b0;
   endtask

   initial begin
      pass_count  = 0;
      check_count = 0;
      rand_mode   = 1'b0;
      wait_script = 1'b0;
      reset       = 1'b1;
      bus.i_req   = 1'b0;
      bus.i_addr  = 32'h0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h0;
      bus.d_wdata = 32'h0;
      bus.d_be    = 4'h0;
      $display("[TB] starting");
      test_reset();
      test_fetch();
      test_write_wait();
      test_readback();
      test_tie();
      test_watchdog();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
